// File: rtl/arg_frame_mover.sv
// Multi-slot argument mover between the operand stack and the local variable array.
// INVOKE pops nargs stack values into LVA slots; RELOAD pushes LVA slots onto the stack.
module arg_frame_mover #(
  parameter int DATA_W   = 32,
  parameter int IDX_W    = 8,
  parameter int MAX_ARGS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [IDX_W-1:0]  nargs,
  input  logic [IDX_W-1:0]  base,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              evalpush,
  output logic              evaltrigger,
  output logic [DATA_W-1:0] evalwrite,
  input  logic [DATA_W-1:0] evalread,
  input  logic              evaldone,
  output logic              lvaop,
  output logic              lvatrigger,
  output logic [IDX_W-1:0]  lvaindex,
  output logic [DATA_W-1:0] lvawrite,
  input  logic [DATA_W-1:0] lvaread,
  input  logic              lvadone
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CHECK    = 3'd1,
    S_SRC_REQ  = 3'd2,
    S_SRC_WAIT = 3'd3,
    S_DST_REQ  = 3'd4,
    S_DST_WAIT = 3'd5,
    S_FINISH   = 3'd6
  } state_t;

  localparam logic [IDX_W:0]   SLOT_LIMIT = {1'b1, {IDX_W{1'b0}}};
  localparam logic [IDX_W-1:0] MAX_ARGS_W = IDX_W'(MAX_ARGS);

  state_t              state_r, state_s;
  logic                mode_r, mode_s;
  logic                reject_r, reject_s;
  logic [IDX_W-1:0]    nargs_r, nargs_s;
  logic [IDX_W-1:0]    base_r, base_s;
  logic [IDX_W-1:0]    cnt_r, cnt_s;
  logic [IDX_W-1:0]    idx_s;
  logic [DATA_W-1:0]   data_r, data_s;
  logic [IDX_W:0]      span_s;

  logic                busy_s, done_s, err_s;
  logic                evalpush_s, evaltrigger_s, lvaop_s, lvatrigger_s;
  logic [DATA_W-1:0]   evalwrite_s, lvawrite_s;
  logic [IDX_W-1:0]    lvaindex_s;

  // Next-state, command latch, slot counter and data latch
  always_comb begin
    state_s  = state_r;
    mode_s   = mode_r;
    reject_s = reject_r;
    nargs_s  = nargs_r;
    base_s   = base_r;
    cnt_s    = cnt_r;
    data_s   = data_r;
    span_s   = {1'b0, base_r} + {1'b0, nargs_r};
    case (state_r)
      S_IDLE: begin
        if (start) begin
          mode_s   = mode;
          nargs_s  = nargs;
          base_s   = base;
          reject_s = 1'b0;
          state_s  = S_CHECK;
        end else begin
          state_s  = S_IDLE;
        end
      end
      S_CHECK: begin
        if ((nargs_r > MAX_ARGS_W) || (span_s > SLOT_LIMIT)) begin
          reject_s = 1'b1;
          state_s  = S_FINISH;
        end else if (nargs_r == {IDX_W{1'b0}}) begin
          state_s  = S_FINISH;
        end else begin
          cnt_s    = nargs_r;
          state_s  = S_SRC_REQ;
        end
      end
      S_SRC_REQ: state_s = S_SRC_WAIT;
      S_SRC_WAIT: begin
        if (mode_r ? lvadone : evaldone) begin
          data_s  = mode_r ? lvaread : evalread;
          state_s = S_DST_REQ;
        end else begin
          state_s = S_SRC_WAIT;
        end
      end
      S_DST_REQ: state_s = S_DST_WAIT;
      S_DST_WAIT: begin
        if (mode_r ? evaldone : lvadone) begin
          cnt_s   = cnt_r - IDX_W'(1);
          state_s = (cnt_r == IDX_W'(1)) ? S_FINISH : S_SRC_REQ;
        end else begin
          state_s = S_DST_WAIT;
        end
      end
      S_FINISH: state_s = S_IDLE;
      default:  state_s = S_IDLE;
    endcase
  end

  // INVOKE fills slots top-down (first pop is the last argument); RELOAD goes bottom-up
  always_comb begin
    if (mode_r) begin
      idx_s = base_r + nargs_r - cnt_s;
    end else begin
      idx_s = base_r + cnt_s - IDX_W'(1);
    end
  end

  // Output values for the upcoming state; address/data ports hold between requests
  always_comb begin
    busy_s        = 1'b0;
    done_s        = 1'b0;
    err_s         = 1'b0;
    evaltrigger_s = 1'b0;
    lvatrigger_s  = 1'b0;
    evalpush_s    = evalpush;
    evalwrite_s   = evalwrite;
    lvaop_s       = lvaop;
    lvaindex_s    = lvaindex;
    lvawrite_s    = lvawrite;
    case (state_s)
      S_CHECK, S_SRC_WAIT, S_DST_WAIT: busy_s = 1'b1;
      S_SRC_REQ: begin
        busy_s = 1'b1;
        if (mode_r) begin
          lvatrigger_s  = 1'b1;
          lvaop_s       = 1'b0;
          lvaindex_s    = idx_s;
        end else begin
          evaltrigger_s = 1'b1;
          evalpush_s    = 1'b0;
        end
      end
      S_DST_REQ: begin
        busy_s = 1'b1;
        if (mode_r) begin
          evaltrigger_s = 1'b1;
          evalpush_s    = 1'b1;
          evalwrite_s   = data_s;
        end else begin
          lvatrigger_s  = 1'b1;
          lvaop_s       = 1'b1;
          lvaindex_s    = idx_s;
          lvawrite_s    = data_s;
        end
      end
      S_FINISH: begin
        done_s = 1'b1;
        err_s  = reject_s;
      end
      default: busy_s = 1'b0;
    endcase
  end

  // State, command and registered output flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_IDLE;
      mode_r      <= 1'b0;
      reject_r    <= 1'b0;
      nargs_r     <= {IDX_W{1'b0}};
      base_r      <= {IDX_W{1'b0}};
      cnt_r       <= {IDX_W{1'b0}};
      data_r      <= {DATA_W{1'b0}};
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      evalpush    <= 1'b0;
      evaltrigger <= 1'b0;
      evalwrite   <= {DATA_W{1'b0}};
      lvaop       <= 1'b0;
      lvatrigger  <= 1'b0;
      lvaindex    <= {IDX_W{1'b0}};
      lvawrite    <= {DATA_W{1'b0}};
    end else begin
      state_r     <= state_s;
      mode_r      <= mode_s;
      reject_r    <= reject_s;
      nargs_r     <= nargs_s;
      base_r      <= base_s;
      cnt_r       <= cnt_s;
      data_r      <= data_s;
      busy        <= busy_s;
      done        <= done_s;
      err         <= err_s;
      evalpush    <= evalpush_s;
      evaltrigger <= evaltrigger_s;
      evalwrite   <= evalwrite_s;
      lvaop       <= lvaop_s;
      lvatrigger  <= lvatrigger_s;
      lvaindex    <= lvaindex_s;
      lvawrite    <= lvawrite_s;
    end
  end

endmodule

// File: tb/tb_arg_frame_mover.sv
// Randomized self-checking bench for arg_frame_mover with behavioural stack and LVA
// slaves; expected memories come from a slot-level model of each command.
module tb_arg_frame_mover;
  localparam int DW = 32;
  localparam int IW = 8;
  localparam int MA = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, mode;
  logic [IW-1:0] nargs, base;
  logic          busy, done, err;
  logic          evalpush, evaltrigger, lvaop, lvatrigger;
  logic [DW-1:0] evalwrite, lvawrite, evalread, lvaread;
  logic [IW-1:0] lvaindex;
  logic          evaldone, lvadone;
  logic          eval_done_slv = 1'b0, eval_stray = 1'b0;
  logic          lva_done_slv = 1'b0, lva_stray = 1'b0;

  assign evaldone = eval_done_slv | eval_stray;
  assign lvadone  = lva_done_slv | lva_stray;

  arg_frame_mover #(.DATA_W(DW), .IDX_W(IW), .MAX_ARGS(MA)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .nargs(nargs), .base(base),
    .busy(busy), .done(done), .err(err),
    .evalpush(evalpush), .evaltrigger(evaltrigger), .evalwrite(evalwrite),
    .evalread(evalread), .evaldone(evaldone),
    .lvaop(lvaop), .lvatrigger(lvatrigger), .lvaindex(lvaindex),
    .lvawrite(lvawrite), .lvaread(lvaread), .lvadone(lvadone)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] stk[$];
  logic [DW-1:0] lva_mem [256];
  int  lva_wr_idx[$];
  int  lva_rd_idx[$];
  bit  rand_lat = 1'b0;
  bit  chk_stab = 1'b1;
  int  lva_extra = 0;
  int  n_eval_trig = 0, n_lva_trig = 0, n_done = 0, n_err = 0, n_overlap = 0;
  int  n_stab_e = 0, n_stab_l = 0;
  int  checks = 0, errors = 0;

  // Stack slave: acts on the strobe, answers with done one or more cycles later
  initial begin
    logic p;
    logic [DW-1:0] w;
    int lat;
    evalread = '0;
    forever begin
      @(negedge clk);
      if (evaltrigger === 1'b1 && rst === 1'b0) begin
        p = evalpush;
        w = evalwrite;
        if (p) stk.push_back(w);
        else if (stk.size() > 0) evalread = stk.pop_back();
        else evalread = '0;
        lat = rand_lat ? $urandom_range(0, 2) : 0;
        for (int i = 0; i <= lat; i++) begin
          @(negedge clk);
          if (chk_stab && (evalpush !== p || (p && evalwrite !== w))) n_stab_e++;
        end
        eval_done_slv = 1'b1;
        @(negedge clk);
        eval_done_slv = 1'b0;
      end
    end
  end

  // LVA slave
  initial begin
    logic o;
    logic [DW-1:0] w;
    logic [IW-1:0] ix;
    int lat;
    lvaread = '0;
    forever begin
      @(negedge clk);
      if (lvatrigger === 1'b1 && rst === 1'b0) begin
        o  = lvaop;
        w  = lvawrite;
        ix = lvaindex;
        if (o) begin lva_mem[ix] = w; lva_wr_idx.push_back(int'(ix)); end
        else begin lvaread = lva_mem[ix]; lva_rd_idx.push_back(int'(ix)); end
        lat = (rand_lat ? $urandom_range(0, 2) : 0) + lva_extra;
        for (int i = 0; i <= lat; i++) begin
          @(negedge clk);
          if (chk_stab && (lvaop !== o || lvaindex !== ix || (o && lvawrite !== w))) n_stab_l++;
        end
        lva_done_slv = 1'b1;
        @(negedge clk);
        lva_done_slv = 1'b0;
      end
    end
  end

  // Event counters
  always @(negedge clk) begin
    if (evaltrigger === 1'b1) n_eval_trig++;
    if (lvatrigger === 1'b1) n_lva_trig++;
    if (evaltrigger === 1'b1 && lvatrigger === 1'b1) n_overlap++;
    if (done === 1'b1) n_done++;
    if (err === 1'b1) n_err++;
  end

  task automatic fill_stack(input int n);
    while (stk.size() < n) stk.push_back($urandom);
  endtask

  task automatic run_cmd(input logic m, input int na, input int bs, input bit poke);
    logic [DW-1:0] exp_stk[$];
    logic [DW-1:0] exp_lva [256];
    bit exp_err, got;
    int e0, l0, d0, r0, cyc, bad, exp_cyc;
    exp_err = (na > MA) || (bs + na > 256);
    exp_stk = stk;
    for (int i = 0; i < 256; i++) exp_lva[i] = lva_mem[i];
    if (!exp_err) begin
      if (m == 1'b0) begin
        for (int i = 0; i < na; i++) exp_lva[bs + i] = stk[stk.size() - na + i];
        repeat (na) void'(exp_stk.pop_back());
      end else begin
        for (int i = 0; i < na; i++) exp_stk.push_back(lva_mem[bs + i]);
      end
    end
    exp_cyc = (exp_err || na == 0) ? 2 : 2 + 4 * na;
    e0 = n_eval_trig; l0 = n_lva_trig; d0 = n_done; r0 = n_err;
    lva_wr_idx.delete();
    lva_rd_idx.delete();
    @(negedge clk);
    start = 1'b1; mode = m; nargs = IW'(na); base = IW'(bs);
    cyc = 0; got = 1'b0;
    while (cyc < 2000 && !got) begin
      @(negedge clk);
      cyc++;
      start = 1'b0; mode = 1'($urandom); nargs = IW'($urandom); base = IW'($urandom);
      if (poke && cyc == 3) begin start = 1'b1; mode = ~m; nargs = 8'd1; base = 8'd0; end
      if (cyc == 1) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_start: got %b want 1", busy); end
      end
      if (done === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got) begin errors++; $display("FAIL done_timeout: mode=%0d nargs=%0d base=%0d", m, na, bs); end
    checks++;
    if (err !== exp_err || busy !== 1'b0)
      begin errors++; $display("FAIL err_busy_at_done: err=%b busy=%b want err=%b busy=0", err, busy, exp_err); end
    if (!rand_lat) begin
      checks++;
      if (cyc !== exp_cyc) begin errors++; $display("FAIL latency: got %0d want %0d", cyc, exp_cyc); end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL done_pulse_width: done=%b err=%b want 0", done, err); end
    repeat (8) @(negedge clk);
    checks++;
    if (n_eval_trig - e0 !== (exp_err ? 0 : na) || n_lva_trig - l0 !== (exp_err ? 0 : na))
      begin errors++; $display("FAIL strobe_count: eval=%0d lva=%0d want %0d", n_eval_trig - e0, n_lva_trig - l0, exp_err ? 0 : na); end
    checks++;
    if (n_done - d0 !== 1 || n_err - r0 !== int'(exp_err))
      begin errors++; $display("FAIL done_err_count: done=%0d err=%0d want 1 %0d", n_done - d0, n_err - r0, exp_err); end
    checks++;
    if (stk != exp_stk) begin errors++; $display("FAIL stack_contents: size %0d want %0d", stk.size(), exp_stk.size()); end
    bad = 0;
    for (int i = 0; i < 256; i++) if (lva_mem[i] !== exp_lva[i]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL lva_contents: %0d slots differ, want 0", bad); end
    bad = 0;
    if (!exp_err && m == 1'b0) begin
      if (lva_wr_idx.size() != na) bad++;
      else for (int i = 0; i < na; i++) if (lva_wr_idx[i] != bs + na - 1 - i) bad++;
    end
    if (!exp_err && m == 1'b1) begin
      if (lva_rd_idx.size() != na) bad++;
      else for (int i = 0; i < na; i++) if (lva_rd_idx[i] != bs + i) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL slot_order: %0d out of order, want 0", bad); end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; mode = 1'b0; nargs = '0; base = '0;
    for (int i = 0; i < 256; i++) lva_mem[i] = $urandom;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, err, evalpush, evaltrigger, lvaop, lvatrigger} !== 7'b0)
      begin errors++; $display("FAIL reset_ctrl: got %b want 0000000", {busy, done, err, evalpush, evaltrigger, lvaop, lvatrigger}); end
    checks++;
    if ({evalwrite, lvawrite, lvaindex} !== '0)
      begin errors++; $display("FAIL reset_data: got %h want 0", {evalwrite, lvawrite, lvaindex}); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_invoke_basic;
    stk.delete();
    stk.push_back(32'd4);
    stk.push_back(32'd5);
    run_cmd(1'b0, 2, 0, 1'b0);
    checks++;
    if (lva_mem[1] !== 32'd5 || lva_mem[0] !== 32'd4 || stk.size() != 0)
      begin errors++; $display("FAIL invoke_basic: lva1=%0d lva0=%0d depth=%0d want 5 4 0", lva_mem[1], lva_mem[0], stk.size()); end
  endtask

  task automatic test_reload_basic;
    stk.delete();
    lva_mem[2] = 32'd7; lva_mem[3] = 32'd8; lva_mem[4] = 32'd9;
    run_cmd(1'b1, 3, 2, 1'b0);
    checks++;
    if (stk.size() != 3 || stk[0] !== 32'd7 || stk[1] !== 32'd8 || stk[2] !== 32'd9)
      begin errors++; $display("FAIL reload_basic: depth=%0d want 7,8,9 with 9 on top", stk.size()); end
  endtask

  task automatic test_zero_and_reject;
    fill_stack(20);
    run_cmd(1'b0, 0, 5, 1'b0);
    run_cmd(1'b1, 0, 0, 1'b0);
    run_cmd(1'b0, 17, 0, 1'b0);
    run_cmd(1'b0, 8, 250, 1'b0);
    run_cmd(1'b1, 16, 240, 1'b0);
    run_cmd(1'b0, 16, 241, 1'b0);
    fill_stack(20);
    run_cmd(1'b0, 16, 240, 1'b0);
  endtask

  task automatic test_busy_start;
    fill_stack(10);
    run_cmd(1'b0, 4, 30, 1'b1);
    run_cmd(1'b1, 3, 100, 1'b1);
  endtask

  task automatic test_stray_done;
    logic [DW-1:0] snap_stk[$];
    int e0, l0, d0;
    snap_stk = stk;
    e0 = n_eval_trig; l0 = n_lva_trig; d0 = n_done;
    @(negedge clk); eval_stray = 1'b1;
    @(negedge clk); eval_stray = 1'b0; lva_stray = 1'b1;
    @(negedge clk); eval_stray = 1'b1;
    @(negedge clk); eval_stray = 1'b0; lva_stray = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (n_eval_trig != e0 || n_lva_trig != l0 || n_done != d0 || busy !== 1'b0 || stk != snap_stk)
      begin errors++; $display("FAIL stray_done: strobes %0d/%0d done %0d busy %b want none", n_eval_trig - e0, n_lva_trig - l0, n_done - d0, busy); end
    fill_stack(5);
    run_cmd(1'b0, 2, 60, 1'b0);
  endtask

  task automatic test_random;
    int m, na, bs;
    rand_lat = 1'b1;
    for (int t = 0; t < 25; t++) begin
      m  = $urandom_range(0, 1);
      na = $urandom_range(0, 18);
      bs = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 240) : $urandom_range(0, 255);
      if (m == 0) fill_stack(na + 2);
      run_cmd(1'(m), na, bs, 1'b0);
    end
    rand_lat = 1'b0;
  endtask

  task automatic test_reset_midflight;
    int k, d0;
    fill_stack(8);
    lva_extra = 3;
    d0 = n_done;
    @(negedge clk);
    start = 1'b1; mode = 1'b0; nargs = 8'd3; base = 8'd10;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (lvatrigger !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    checks++;
    if (k >= 100) begin errors++; $display("FAIL midflight_no_lva_strobe: waited %0d cycles", k); end
    @(negedge clk);
    chk_stab = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, err, evalpush, evaltrigger, lvaop, lvatrigger} !== 7'b0 || {evalwrite, lvawrite, lvaindex} !== '0)
      begin errors++; $display("FAIL midflight_reset_outputs: busy=%b lvaop=%b lvaindex=%0d want all 0", busy, lvaop, lvaindex); end
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (n_done != d0 || busy !== 1'b0)
      begin errors++; $display("FAIL midflight_abandon: done=%0d busy=%b want 0 0", n_done - d0, busy); end
    chk_stab = 1'b1;
    lva_extra = 0;
    fill_stack(8);
    run_cmd(1'b0, 3, 10, 1'b0);
  endtask

  initial begin
    test_reset();
    test_invoke_basic();
    test_reload_basic();
    test_zero_and_reject();
    test_busy_start();
    test_stray_done();
    test_random();
    test_reset_midflight();
    checks++;
    if (n_overlap != 0 || n_stab_e != 0 || n_stab_l != 0)
      begin errors++; $display("FAIL strobe_overlap_stability: overlap=%0d stab=%0d/%0d want 0", n_overlap, n_stab_e, n_stab_l); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
